tx_ordered_set_ctrl: RTL and testbench

TX_ORDERED_SET_CTRL -- requirements
Module: tx_ordered_set_ctrl

---
 rtl/tx_ordered_set_ctrl.sv | 140 ++++++++++++++
 tb/tb_tx_ordered_set_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ordered_set_ctrl.sv
// Ordered-set scheduler for a 1000BASE-X PCS transmitter: interleaves /I/, /C1/ /C2/ and packet data.
// All registers update on the falling edge of clock; every output describes the code-group of the current cycle.
//
//   state  | meaning
//   IDLE   | /K28.5/D5.6/ idle pairs, mode changes decided on the odd cycle
//   CFG_C1 | /K28.5/D21.5/cfg_lo/cfg_hi/ first half of a config pair
//   CFG_C2 | /K28.5/D2.2/cfg_lo/cfg_hi/ second half, mode decided at its end
//   DATA   | code-groups passed through from the packet transmit FSM
module tx_ordered_set_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  xmit,
  input  logic [15:0] tx_config_reg,
  input  logic [7:0]  tx_o_set,
  input  logic        transmitting,
  output logic [7:0]  tx_code_group,
  output logic        tx_k,
  output logic        tx_even,
  output logic        TX_OSET_indicate,
  output logic [1:0]  xmit_active,
  output logic        dp_sel
);

  localparam logic [1:0] XMIT_IDLE = 2'b00;
  localparam logic [1:0] XMIT_CFG  = 2'b01;
  localparam logic [1:0] XMIT_DATA = 2'b10;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;

  typedef enum logic [1:0] {IDLE, CFG_C1, CFG_C2, DATA} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [15:0] cfg_q, cfg_nxt;
  logic        even_nxt;
  logic [7:0]  code_nxt;
  logic        k_nxt, ind_nxt, dp_nxt;
  logic [1:0]  xa_nxt;

  always_ff @(negedge clock) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 2'd0;
      cfg_q            <= 16'h0000;
      tx_even          <= 1'b1;
      tx_code_group    <= K28_5;
      tx_k             <= 1'b1;
      TX_OSET_indicate <= 1'b0;
      xmit_active      <= XMIT_IDLE;
      dp_sel           <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      cfg_q            <= cfg_nxt;
      tx_even          <= even_nxt;
      tx_code_group    <= code_nxt;
      tx_k             <= k_nxt;
      TX_OSET_indicate <= ind_nxt;
      xmit_active      <= xa_nxt;
      dp_sel           <= dp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 2'd1;
    cfg_nxt   = cfg_q;
    even_nxt  = ~tx_even;
    code_nxt  = K28_5;
    k_nxt     = 1'b0;
    ind_nxt   = 1'b0;
    xa_nxt    = XMIT_IDLE;
    dp_nxt    = 1'b0;

    // tx_even=0 marks the odd cycle, i.e. the end of an idle pair or data pair
    case (state)
      IDLE: begin
        if (!tx_even) begin
          if (xmit == XMIT_DATA)     state_nxt = DATA;
          else if (xmit == XMIT_CFG) state_nxt = CFG_C1;
        end
      end
      CFG_C1: begin
        if (cnt == 2'd3) state_nxt = CFG_C2;
      end
      CFG_C2: begin
        if (cnt == 2'd3) begin
          if (xmit == XMIT_CFG)       state_nxt = CFG_C1;
          else if (xmit == XMIT_DATA) state_nxt = DATA;
          else                        state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!tx_even && !transmitting && xmit != XMIT_DATA)
          state_nxt = (xmit == XMIT_CFG) ? CFG_C1 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) cnt_nxt = 2'd0;

    // Snapshot the config word at the start of each set so cfg_lo/cfg_hi stay coherent
    if ((state_nxt == CFG_C1 || state_nxt == CFG_C2) && cnt_nxt == 2'd0)
      cfg_nxt = tx_config_reg;

    case (state_nxt)
      IDLE: begin
        code_nxt = even_nxt ? K28_5 : D5_6;
        k_nxt    = even_nxt;
        ind_nxt  = ~even_nxt;
      end
      CFG_C1, CFG_C2: begin
        xa_nxt  = XMIT_CFG;
        ind_nxt = (cnt_nxt == 2'd3);
        case (cnt_nxt)
          2'd0: begin
            code_nxt = K28_5;
            k_nxt    = 1'b1;
          end
          2'd1:    code_nxt = (state_nxt == CFG_C1) ? D21_5 : D2_2;
          2'd2:    code_nxt = cfg_nxt[7:0];
          default: code_nxt = cfg_nxt[15:8];
        endcase
      end
      DATA: begin
        xa_nxt   = XMIT_DATA;
        dp_nxt   = 1'b1;
        code_nxt = tx_o_set;
        ind_nxt  = ~even_nxt;
        k_nxt    = (tx_o_set == 8'hBC) || (tx_o_set == 8'hFB) ||
                   (tx_o_set == 8'hF7) || (tx_o_set == 8'hFD);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_ordered_set_ctrl.sv
// Bench for tx_ordered_set_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a mode/position/parity model.
module tb_tx_ordered_set_ctrl;

  logic        clock;
  logic        reset;
  logic [1:0]  xmit;
  logic [15:0] tx_config_reg;
  logic [7:0]  tx_o_set;
  logic        transmitting;
  logic [7:0]  tx_code_group;
  logic        tx_k;
  logic        tx_even;
  logic        TX_OSET_indicate;
  logic [1:0]  xmit_active;
  logic        dp_sel;

  tx_ordered_set_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .xmit             (xmit),
    .tx_config_reg    (tx_config_reg),
    .tx_o_set         (tx_o_set),
    .transmitting     (transmitting),
    .tx_code_group    (tx_code_group),
    .tx_k             (tx_k),
    .tx_even          (tx_even),
    .TX_OSET_indicate (TX_OSET_indicate),
    .xmit_active      (xmit_active),
    .dp_sel           (dp_sel)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: mode 0=idle 1=C1 2=C2 3=data; pos = cycles spent in mode; m_n = cycles since reset
  int          m_mode, m_pos, m_n;
  logic [15:0] m_cfg;
  logic [7:0]  m_byte;
  bit          m_valid = 0;

  function automatic int mode_of(input logic [1:0] x);
    if (x == 2'b10) return 3;
    if (x == 2'b01) return 1;
    return 0;
  endfunction

  function automatic bit is_k(input logic [7:0] b);
    return b == 8'hBC || b == 8'hFB || b == 8'hF7 || b == 8'hFD;
  endfunction

  always @(negedge clock) begin
    int  nm;
    bit  odd;
    if (reset) begin
      m_mode  = 0;
      m_pos   = 0;
      m_n     = 0;
      m_valid = 1;
    end else if (m_valid) begin
      nm  = m_mode;
      odd = (m_n % 2) == 1;
      case (m_mode)
        0: if (odd) nm = mode_of(xmit);
        1: if (m_pos % 4 == 3) nm = 2;
        2: if (m_pos % 4 == 3) nm = mode_of(xmit);
        default: if (odd && !transmitting && xmit != 2'b10) nm = mode_of(xmit);
      endcase
      m_pos  = (nm != m_mode) ? 0 : m_pos + 1;
      m_mode = nm;
      m_n++;
      if ((m_mode == 1 || m_mode == 2) && m_pos == 0) m_cfg = tx_config_reg;
      m_byte = tx_o_set;
    end
  end

  always @(posedge clock) begin
    logic [7:0] e_code;
    logic [7:0] seq [4];
    bit         e_k, e_ind, e_dp, e_even;
    int         e_xa;
    if (m_valid) begin
      e_even = (m_n % 2) == 0;
      if (m_mode == 0) begin
        e_code = e_even ? 8'hBC : 8'hC5;
        e_k = e_even; e_ind = !e_even; e_xa = 0; e_dp = 0;
      end else if (m_mode == 3) begin
        e_code = m_byte;
        e_k = is_k(m_byte); e_ind = !e_even; e_xa = 2; e_dp = 1;
      end else begin
        seq[0] = 8'hBC;
        seq[1] = (m_mode == 1) ? 8'hB5 : 8'h42;
        seq[2] = m_cfg[7:0];
        seq[3] = m_cfg[15:8];
        e_code = seq[m_pos % 4];
        e_k = (m_pos == 0); e_ind = (m_pos == 3); e_xa = 1; e_dp = 0;
      end
      chk("code", tx_code_group, e_code);
      chk("k", tx_k, e_k);
      chk("even", tx_even, e_even);
      chk("oset_ind", TX_OSET_indicate, e_ind);
      chk("xmit_active", xmit_active, e_xa);
      chk("dp_sel", dp_sel, e_dp);
    end
  end

  task automatic wait_code(input logic [7:0] c, input int lim);
    bit found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      @(posedge clock);
      if (tx_code_group == c) found = 1;
    end
    chk("wait_code", found, 1);
  endtask

  task automatic wait_xa(input logic [1:0] a, input int lim);
    bit found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      @(posedge clock);
      if (xmit_active == a) found = 1;
    end
    chk("wait_xmit_active", found, 1);
  endtask

  initial begin
    logic [7:0] cfg_seq [8];
    logic [7:0] pkt     [5];
    bit         pkt_k   [5];
    logic [7:0] kset    [4];
    logic [31:0] r;

    reset = 1; xmit = 2'b00; tx_config_reg = 16'h01A0; tx_o_set = 8'h00; transmitting = 0;
    repeat (3) @(posedge clock);
    reset = 0;
    chk("rst_code", tx_code_group, 8'hBC);
    chk("rst_k", tx_k, 1);
    chk("rst_even", tx_even, 1);
    chk("rst_ind", TX_OSET_indicate, 0);
    chk("rst_xa", xmit_active, 0);
    chk("rst_dp", dp_sel, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      chk("idle_code", tx_code_group, (i % 2 == 0) ? 8'hC5 : 8'hBC);
      chk("idle_even", tx_even, (i % 2 == 0) ? 0 : 1);
      chk("idle_ind", TX_OSET_indicate, (i % 2 == 0) ? 1 : 0);
    end

    // Config pair with 16'h01A0, checked from the first /D21.5/
    xmit = 2'b01;
    wait_code(8'hB5, 12);
    cfg_seq = '{8'hB5, 8'hA0, 8'h01, 8'hBC, 8'h42, 8'hA0, 8'h01, 8'hBC};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(posedge clock);
      chk("cfg_code", tx_code_group, cfg_seq[i]);
      chk("cfg_k", tx_k, (cfg_seq[i] == 8'hBC) ? 1 : 0);
    end

    // Request DATA at C1 cnt=1: C1 and C2 finish before DATA starts
    @(posedge clock);
    chk("c1_cnt1", tx_code_group, 8'hB5);
    xmit = 2'b10; tx_o_set = 8'h55; transmitting = 1;
    for (int i = 2; i < 8; i++) begin
      @(posedge clock);
      chk("cfg_finish", tx_code_group, cfg_seq[i - 1]);
    end
    @(posedge clock);
    chk("data_first_dp", dp_sel, 1);
    chk("data_first_even", tx_even, 1);
    chk("data_first_xa", xmit_active, 2);
    chk("data_first_code", tx_code_group, 8'h55);

    // Packet bytes with xmit dropped mid-packet
    pkt   = '{8'hFB, 8'h55, 8'hD5, 8'hFD, 8'hF7};
    pkt_k = '{1, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      tx_o_set = pkt[i];
      if (i == 1) xmit = 2'b00;
      @(posedge clock);
      chk("pkt_code", tx_code_group, pkt[i]);
      chk("pkt_k", tx_k, pkt_k[i]);
      chk("pkt_dp", dp_sel, 1);
    end
    transmitting = 0; tx_o_set = 8'h07;
    wait_xa(2'b00, 6);
    chk("post_pkt_code", tx_code_group, 8'hBC);
    chk("post_pkt_even", tx_even, 1);

    // xmit=11 behaves as idle; a one-cycle DATA pulse on an even cycle is ignored
    xmit = 2'b11;
    repeat (6) @(posedge clock);
    chk("xmit11_xa", xmit_active, 0);
    xmit = 2'b00;
    @(posedge clock);
    if (!tx_even) @(posedge clock);
    xmit = 2'b10;
    @(posedge clock);
    xmit = 2'b00;
    repeat (4) begin
      @(posedge clock);
      chk("pulse_xa", xmit_active, 0);
    end

    // Reset during C2 cnt=2
    xmit = 2'b01;
    wait_code(8'h42, 16);
    @(posedge clock);
    chk("c2_cnt2", tx_code_group, 8'hA0);
    reset = 1;
    @(posedge clock);
    reset = 0;
    chk("mid_rst_code", tx_code_group, 8'hBC);
    chk("mid_rst_even", tx_even, 1);
    chk("mid_rst_xa", xmit_active, 0);

    // Randomized traffic, checked by the model every cycle
    kset = '{8'hBC, 8'hFB, 8'hF7, 8'hFD};
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      if ($urandom_range(7) == 0) xmit = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) begin
        r = $urandom;
        tx_config_reg = r[15:0];
      end
      r = $urandom;
      tx_o_set = ($urandom_range(3) == 0) ? kset[$urandom_range(3)] : r[7:0];
      if ($urandom_range(9) == 0) transmitting = !transmitting;
      reset = ($urandom_range(299) == 0);
    end
    reset = 0;
    repeat (2) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
